// File: rtl/spi_flash_controller.sv
// SPI mode-0 master that fetches 16-bit flash words and reads/writes PSRAM bytes over a shared bus.
// Define SPI_FLASH_FAST_READ_EN to switch flash reads to command 0x0B with 8 dummy bits.
module spi_flash_controller (
    input  logic        clk_in,
    input  logic        reset_in,
    output logic        sclk_out,
    output logic        flash_cs_out,
    output logic        psram_cs_out,
    output logic        mosi_out,
    input  logic        miso_in,
    input  logic [15:0] addr_in,
    input  logic        addr_valid_in,
    input  logic [1:0]  mem_type_in,
    input  logic [7:0]  psram_data_in,
    output logic [15:0] flash_data_out,
    output logic        flash_data_valid_out,
    output logic [7:0]  psram_data_out,
    output logic        psram_data_valid_out,
    output logic        busy_out
);

    // state    | meaning
    // ST_IDLE  | bus idle, waiting for a request
    // ST_CMD   | shifting the 8-bit command
    // ST_ADDR  | shifting the 24-bit address
    // ST_DUMMY | 8 dummy bits (fast flash read only)
    // ST_DATA  | data bits, then one sclk-low tail cycle with bit count at zero
    // ST_DONE  | CS released, valid pulse, bus free again
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_DONE
    } state_t;

    localparam logic [1:0] TYPE_IMEM_READ  = 2'b00;
    localparam logic [1:0] TYPE_DMEM_READ  = 2'b01;
    localparam logic [1:0] TYPE_DMEM_WRITE = 2'b10;
    localparam logic [1:0] TYPE_RSVD       = 2'b11;

`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] FLASH_CMD = 8'h0B;
    localparam logic       FAST_READ = 1'b1;
`else
    localparam logic [7:0] FLASH_CMD = 8'h03;
    localparam logic       FAST_READ = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        sclk_q, sclk_d;
    logic [1:0]  type_q, type_d;
    logic [39:0] tx_q, tx_d;
    logic [15:0] rx_q, rx_d;
    logic [15:0] flash_data_q, flash_data_d;
    logic [7:0]  psram_data_q, psram_data_d;

    logic       start;
    logic       in_frame;
    logic [7:0] cmd_sel;

    assign start = addr_valid_in && (mem_type_in != TYPE_RSVD);

    always_comb begin
        cmd_sel = 8'h03;
        if (mem_type_in == TYPE_IMEM_READ) begin
            cmd_sel = FLASH_CMD;
        end else if (mem_type_in == TYPE_DMEM_WRITE) begin
            cmd_sel = 8'h02;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        sclk_d       = sclk_q;
        type_d       = type_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        flash_data_d = flash_data_q;
        psram_data_d = psram_data_q;

        case (state_q)
            // DONE drops busy, so a request arriving then is taken on the edge leaving DONE
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                sclk_d  = 1'b0;
                if (start) begin
                    state_d   = ST_CMD;
                    bit_cnt_d = 5'd8;
                    type_d    = mem_type_in;
                    tx_d      = {cmd_sel, 8'h00, addr_in,
                                 (mem_type_in == TYPE_DMEM_WRITE) ? psram_data_in : 8'h00};
                end
            end
            ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
                if (bit_cnt_q == 5'd0) begin
                    state_d = ST_DONE;
                    if (type_q == TYPE_IMEM_READ) begin
                        flash_data_d = rx_q;
                    end else if (type_q == TYPE_DMEM_READ) begin
                        psram_data_d = rx_q[7:0];
                    end
                end else if (!sclk_q) begin
                    sclk_d = 1'b1;
                end else begin
                    // falling SCLK: advance MOSI, capture MISO
                    sclk_d    = 1'b0;
                    tx_d      = {tx_q[38:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - 5'd1;
                    if (state_q == ST_DATA) begin
                        rx_d = {rx_q[14:0], miso_in};
                    end
                    if (bit_cnt_q == 5'd1) begin
                        case (state_q)
                            ST_CMD: begin
                                state_d   = ST_ADDR;
                                bit_cnt_d = 5'd24;
                            end
                            ST_ADDR: begin
                                if (FAST_READ && (type_q == TYPE_IMEM_READ)) begin
                                    state_d   = ST_DUMMY;
                                    bit_cnt_d = 5'd8;
                                end else begin
                                    state_d   = ST_DATA;
                                    bit_cnt_d = (type_q == TYPE_IMEM_READ) ? 5'd16 : 5'd8;
                                end
                            end
                            ST_DUMMY: begin
                                state_d   = ST_DATA;
                                bit_cnt_d = 5'd16;
                            end
                            default: state_d = state_q;
                        endcase
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 5'd0;
            sclk_q       <= 1'b0;
            type_q       <= TYPE_IMEM_READ;
            tx_q         <= 40'h0;
            rx_q         <= 16'h0;
            flash_data_q <= 16'h0000;
            psram_data_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            sclk_q       <= sclk_d;
            type_q       <= type_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            flash_data_q <= flash_data_d;
            psram_data_q <= psram_data_d;
        end
    end

    assign in_frame = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                      (state_q == ST_DUMMY) || (state_q == ST_DATA);

    assign busy_out     = in_frame;
    assign flash_cs_out = !(in_frame && (type_q == TYPE_IMEM_READ));
    assign psram_cs_out = !(in_frame && (type_q != TYPE_IMEM_READ));
    assign sclk_out     = sclk_q;
    // read data phases keep MOSI low; tx_q is only meaningful until data starts
    assign mosi_out     = tx_q[39] && ((state_q == ST_CMD) || (state_q == ST_ADDR) ||
                                       (state_q == ST_DUMMY) ||
                                       ((state_q == ST_DATA) && (type_q == TYPE_DMEM_WRITE)));

    assign flash_data_out       = flash_data_q;
    assign psram_data_out       = psram_data_q;
    assign flash_data_valid_out = (state_q == ST_DONE) && (type_q == TYPE_IMEM_READ);
    assign psram_data_valid_out = (state_q == ST_DONE) && (type_q != TYPE_IMEM_READ);

endmodule

// File: tb/tb_spi_flash_controller.sv
// Bench for spi_flash_controller: SPI memory device model, cycle-timeline reference model, directed requests.
module tb_spi_flash_controller;

`ifdef SPI_FLASH_FAST_READ_EN
    localparam int         IMEM_N    = 56;
    localparam logic [7:0] IMEM_CMD  = 8'h0B;
    localparam int         IMEM_BUSY = 113;
`else
    localparam int         IMEM_N    = 48;
    localparam logic [7:0] IMEM_CMD  = 8'h03;
    localparam int         IMEM_BUSY = 97;
`endif

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b0;
    logic        sclk_out, flash_cs_out, psram_cs_out, mosi_out;
    logic        miso_in = 1'b0;
    logic [15:0] addr_in = 16'h0;
    logic        addr_valid_in = 1'b0;
    logic [1:0]  mem_type_in = 2'b00;
    logic [7:0]  psram_data_in = 8'h00;
    logic [15:0] flash_data_out;
    logic        flash_data_valid_out;
    logic [7:0]  psram_data_out;
    logic        psram_data_valid_out;
    logic        busy_out;

    always #5 clk_in = ~clk_in;

    spi_flash_controller dut (
        .clk_in(clk_in), .reset_in(reset_in), .sclk_out(sclk_out),
        .flash_cs_out(flash_cs_out), .psram_cs_out(psram_cs_out),
        .mosi_out(mosi_out), .miso_in(miso_in), .addr_in(addr_in),
        .addr_valid_in(addr_valid_in), .mem_type_in(mem_type_in),
        .psram_data_in(psram_data_in), .flash_data_out(flash_data_out),
        .flash_data_valid_out(flash_data_valid_out), .psram_data_out(psram_data_out),
        .psram_data_valid_out(psram_data_valid_out), .busy_out(busy_out)
    );

    int checks = 0;
    int errors = 0;

    int busy_cnt = 0, fvalid_cnt = 0, pvalid_cnt = 0, fcs_low_cnt = 0, pcs_low_cnt = 0;

    function automatic logic [7:0] flash_byte(input int a);
        case (a)
            4:       return 8'hA5;
            5:       return 8'h3C;
            256:     return 8'h12;
            257:     return 8'h34;
            default: return 8'hFF;
        endcase
    endfunction

    logic [7:0] dev_psram [0:65535];
    logic [7:0] ref_psram [0:65535];
    initial begin
        for (int i = 0; i < 65536; i++) begin
            dev_psram[i] = 8'h00;
            ref_psram[i] = 8'h00;
        end
    end

    // SPI memory device: samples MOSI on SCLK rise, presents MISO for the following fall
    logic [63:0] sl_shift = 64'h0;
    logic [63:0] last_frame = 64'h0;
    int          sl_bits = 0;
    int          last_bits = 0;
    logic [7:0]  sl_cmd = 8'h00;
    logic [23:0] sl_addr = 24'h0;

    always @(posedge sclk_out or posedge flash_cs_out or posedge psram_cs_out) begin
        int ds, k;
        logic [7:0] b;
        if (sclk_out && (!flash_cs_out || !psram_cs_out)) begin
            sl_shift = {sl_shift[62:0], mosi_out};
            sl_bits++;
            if (sl_bits == 8) sl_cmd = sl_shift[7:0];
            if (sl_bits == 32) sl_addr = sl_shift[23:0];
            if (!flash_cs_out) begin
                ds = (sl_cmd == 8'h0B) ? 40 : 32;
                if (sl_bits > ds && (sl_cmd == 8'h03 || sl_cmd == 8'h0B)) begin
                    k = sl_bits - 1 - ds;
                    b = flash_byte(int'(sl_addr) + k / 8);
                    miso_in = b[7 - (k % 8)];
                end
            end else begin
                if (sl_cmd == 8'h03 && sl_bits > 32) begin
                    k = sl_bits - 33;
                    b = dev_psram[sl_addr[15:0]];
                    if (k < 8) miso_in = b[7 - k];
                end
                if (sl_cmd == 8'h02 && sl_bits == 40) dev_psram[sl_addr[15:0]] = sl_shift[7:0];
            end
        end else if (flash_cs_out && psram_cs_out) begin
            last_frame = sl_shift;
            last_bits  = sl_bits;
            sl_bits    = 0;
            sl_shift   = 64'h0;
            miso_in    = 1'b0;
        end
    end

    // Reference model: each request is a timeline of cycle offsets from acceptance.
    // Offsets 1..2N+1 busy with CS low, SCLK high on even offsets up to 2N, DONE at 2N+2.
    initial begin
        int          cyc, nb;
        logic [1:0]  kind;
        logic [55:0] frame;
        logic [15:0] ma;
        logic [15:0] e_f;
        logic [7:0]  e_p;
        logic        act, don;
        logic [30:0] exp_v, got_v;
        cyc = 0; nb = 0; kind = 2'b00; frame = 56'h0; ma = 16'h0; e_f = 16'h0; e_p = 8'h0;
        forever begin
            @(negedge clk_in);
            if (!reset_in) begin
                cyc = 0;
                e_f = 16'h0000;
                e_p = 8'h00;
            end
            act = (cyc >= 1) && (cyc <= 2 * nb + 1);
            don = (cyc != 0) && (cyc == 2 * nb + 2);
            exp_v = {act,
                     !(act && kind == 2'b00),
                     !(act && kind != 2'b00),
                     act && (cyc <= 2 * nb) && (cyc % 2 == 0),
                     (act && cyc <= 2 * nb) ? frame[55 - (cyc - 1) / 2] : 1'b0,
                     don && kind == 2'b00,
                     don && kind != 2'b00,
                     e_f, e_p};
            got_v = {busy_out, flash_cs_out, psram_cs_out, sclk_out, mosi_out,
                     flash_data_valid_out, psram_data_valid_out, flash_data_out, psram_data_out};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL cycle_model t=%0t offset=%0d got %h expected %h", $time, cyc, got_v, exp_v);
            end
            if (busy_out) busy_cnt++;
            if (flash_data_valid_out) fvalid_cnt++;
            if (psram_data_valid_out) pvalid_cnt++;
            if (!flash_cs_out) fcs_low_cnt++;
            if (!psram_cs_out) pcs_low_cnt++;

            if (reset_in) begin
                if (cyc == 0 || cyc == 2 * nb + 2) begin
                    if (addr_valid_in && mem_type_in != 2'b11) begin
                        cyc  = 1;
                        kind = mem_type_in;
                        ma   = addr_in;
                        case (mem_type_in)
                            2'b00: begin
                                nb = IMEM_N;
                                frame = {IMEM_CMD, 8'h00, addr_in, 24'h0};
                            end
                            2'b01: begin
                                nb = 40;
                                frame = {8'h03, 8'h00, addr_in, 24'h0};
                            end
                            default: begin
                                nb = 40;
                                frame = {8'h02, 8'h00, addr_in, psram_data_in, 16'h0};
                            end
                        endcase
                    end else begin
                        cyc = 0;
                    end
                end else begin
                    cyc++;
                    if (cyc == 2 * nb + 2) begin
                        if (kind == 2'b00) e_f = {flash_byte(int'(ma)), flash_byte(int'(ma) + 1)};
                        else if (kind == 2'b01) e_p = ref_psram[ma];
                        else ref_psram[ma] = frame[23:16];
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic clear_counts();
        busy_cnt = 0; fvalid_cnt = 0; pvalid_cnt = 0; fcs_low_cnt = 0; pcs_low_cnt = 0;
    endtask

    task automatic do_req(input logic [1:0] t, input logic [15:0] a, input logic [7:0] d);
        @(posedge clk_in); #2;
        mem_type_in = t; addr_in = a; psram_data_in = d; addr_valid_in = 1'b1;
        @(posedge clk_in); #2;
        addr_valid_in = 1'b0;
    endtask

    task automatic run_req(input logic [1:0] t, input logic [15:0] a, input logic [7:0] d);
        clear_counts();
        do_req(t, a, d);
        repeat (2 * 56 + 8) @(posedge clk_in);
        #2;
    endtask

    initial begin
        repeat (4) @(posedge clk_in);
        #2;
        chk("reset_pins", {flash_cs_out, psram_cs_out, busy_out, sclk_out, mosi_out}, 5'b11000);
        chk("reset_data", {flash_data_out, psram_data_out}, 24'h0);
        reset_in = 1'b1;
        repeat (2) @(posedge clk_in);

        run_req(2'b00, 16'h0004, 8'h00);
        chk("imem_data", flash_data_out, 16'hA53C);
        chk("imem_busy_len", busy_cnt, IMEM_BUSY);
        chk("imem_valid_cnt", fvalid_cnt, 1);
        chk("imem_psram_cs", pcs_low_cnt, 0);
        chk("imem_bits", last_bits, IMEM_N);
        chk("imem_hdr", (last_frame >> (last_bits - 32)) & 64'hFFFF_FFFF, {IMEM_CMD, 24'h000004});

        run_req(2'b01, 16'h0004, 8'h00);
        chk("dread0_data", psram_data_out, 8'h00);
        chk("dread0_busy_len", busy_cnt, 81);
        chk("dread0_valid", pvalid_cnt, 1);
        chk("dread0_flash_cs", fcs_low_cnt, 0);

        run_req(2'b10, 16'h0004, 8'h55);
        chk("dwrite_frame", last_frame[39:0], 40'h0200000455);
        chk("dwrite_bits", last_bits, 40);
        chk("dwrite_valid", pvalid_cnt, 1);
        chk("dwrite_hold", psram_data_out, 8'h00);

        run_req(2'b01, 16'h0004, 8'h00);
        chk("dread1_data", psram_data_out, 8'h55);

        run_req(2'b00, 16'h0100, 8'h00);
        chk("imem2_data", flash_data_out, 16'h1234);
        chk("imem2_hold_psram", psram_data_out, 8'h55);

        run_req(2'b10, 16'h00FF, 8'hC3);
        run_req(2'b01, 16'h00FF, 8'h00);
        chk("dread2_data", psram_data_out, 8'hC3);

        clear_counts();
        do_req(2'b00, 16'h0004, 8'h00);
        repeat (20) @(posedge clk_in);
        do_req(2'b01, 16'h0008, 8'h00);
        repeat (110) @(posedge clk_in);
        #2;
        chk("busy_ignore_fvalid", fvalid_cnt, 1);
        chk("busy_ignore_pvalid", pvalid_cnt, 0);
        chk("busy_ignore_pcs", pcs_low_cnt, 0);
        chk("busy_ignore_data", flash_data_out, 16'hA53C);

        clear_counts();
        do_req(2'b00, 16'h0004, 8'h00);
        repeat (30) @(posedge clk_in);
        #2;
        reset_in = 1'b0;
        #1;
        chk("abort_pins", {flash_cs_out, psram_cs_out, busy_out, sclk_out}, 4'b1100);
        repeat (3) @(posedge clk_in);
        #2;
        reset_in = 1'b1;
        repeat (130) @(posedge clk_in);
        #2;
        chk("abort_no_valid", fvalid_cnt, 0);
        chk("abort_data_clr", flash_data_out, 16'h0000);
        run_req(2'b00, 16'h0004, 8'h00);
        chk("after_abort_data", flash_data_out, 16'hA53C);
        chk("after_abort_valid", fvalid_cnt, 1);

        clear_counts();
        do_req(2'b11, 16'h0004, 8'h00);
        repeat (20) @(posedge clk_in);
        #2;
        chk("rsvd_activity", busy_cnt + fcs_low_cnt + pcs_low_cnt, 0);

        @(posedge clk_in);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
